// File: rtl/cmlb_refill.sv
// cmlb_refill: instruction-side translation miss handler feeding the code MLB.
// Walks a 3-level page table (16 KB pages) through a single-outstanding PTE
// read port and either writes the leaf entry into the MLB or raises a fault.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   miss_valid/ready      miss handshake (ready only while idle)
//   miss_addr, miss_tr    faulting fetch address, translated-jump lookup flag
//   root_base             page-table root, sampled when a miss is accepted
//   flush                 abort the current walk
//   mem_req_*             PTE read request (valid/addr/ready)
//   mem_rsp_*             PTE read return (valid/data)
//   wr_stall              MLB stall; holds the write while high
//   wr_wen/tr/addr/data   MLB write port
//   fault_valid/addr      one-cycle fetch fault report
//   busy                  walker not idle
module cmlb_refill #(
    parameter int unsigned PTE_W = 64,
    parameter int unsigned PA_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [64:0]       miss_addr,
    input  logic              miss_tr,
    output logic              miss_ready,
    input  logic [PA_W-1:0]   root_base,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [PA_W-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [PTE_W-1:0]  mem_rsp_data,
    input  logic              wr_stall,
    output logic              wr_wen,
    output logic              wr_tr,
    output logic [64:0]       wr_addr,
    output logic [PTE_W-1:0]  wr_data,
    output logic              fault_valid,
    output logic [64:0]       fault_addr,
    output logic              busy
);

    localparam int unsigned ADDR_W = 65;
    localparam int unsigned OFF_W  = 14;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned LVL_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_FAULT,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PA_W-1:0]     base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tr_q, tr_d;
    logic [PTE_W-1:0]    pte_q, pte_d;

    // Leaf level overwrites these PTE bits on the write port, so they are never consumed.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^mem_rsp_data[13:12];

    // Table index for a given walk level.
    function automatic logic [IDX_W-1:0] level_index(input logic [LVL_W-1:0] lvl,
                                                     input logic [ADDR_W-1:0] a);
        case (lvl)
            2'd0:    level_index = a[43:34];
            2'd1:    level_index = a[33:24];
            default: level_index = a[23:14];
        endcase
    endfunction

    // Next-state and captured-register logic.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        base_d  = base_q;
        addr_d  = addr_q;
        tr_d    = tr_q;
        pte_d   = pte_q;

        case (state_q)
            S_IDLE: begin
                // Untranslated window misses are accepted and retired without a walk.
                if (miss_valid && !flush && (miss_addr[43:40] != 4'b1110)) begin
                    addr_d  = miss_addr;
                    tr_d    = miss_tr;
                    base_d  = root_base;
                    level_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    // An accepted request still owes us a response that must be drained.
                    state_d = mem_req_ready ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid) begin
                    if (!mem_rsp_data[0] || (!mem_rsp_data[1] && (level_q == 2'd2))) begin
                        state_d = S_FAULT;
                    end else if (mem_rsp_data[1]) begin
                        // Stored already in write-port form: leaf level in bits [13:12].
                        pte_d   = {mem_rsp_data[PTE_W-1:OFF_W], level_q, mem_rsp_data[11:0]};
                        state_d = S_WRITE;
                    end else begin
                        base_d  = {mem_rsp_data[PA_W-1:OFF_W], {OFF_W{1'b0}}};
                        level_d = level_q + 2'd1;
                        state_d = S_REQ;
                    end
                end
            end
            S_WRITE: begin
                if (flush || !wr_stall) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured registers and registered outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            base_q        <= '0;
            addr_q        <= '0;
            tr_q          <= 1'b0;
            pte_q         <= '0;
            miss_ready    <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            wr_wen        <= 1'b0;
            fault_valid   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            base_q        <= base_d;
            addr_q        <= addr_d;
            tr_q          <= tr_d;
            pte_q         <= pte_d;
            miss_ready    <= (state_d == S_IDLE);
            mem_req_valid <= (state_d == S_REQ);
            // Aligned base plus a sub-page offset: modulo-2^PA_W add, carry dropped.
            mem_req_addr  <= base_d + PA_W'({level_index(level_d, addr_d), 3'b000});
            wr_wen        <= (state_d == S_WRITE);
            fault_valid   <= (state_d == S_FAULT);
            busy          <= (state_d != S_IDLE);
        end
    end

    assign wr_tr      = tr_q;
    assign wr_addr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign wr_data    = pte_q;
    assign fault_addr = addr_q;

endmodule

// File: tb/tb_cmlb_refill.sv
// Directed self-checking bench for cmlb_refill.
module tb_cmlb_refill;

    localparam int unsigned PTE_W  = 64;
    localparam int unsigned PA_W   = 64;
    localparam int unsigned ADDR_W = 65;

    localparam logic [ADDR_W-1:0] A1   = 65'h0_0000_0400_0123_4000;
    localparam logic [ADDR_W-1:0] A2   = 65'h0_0000_0400_0123_4567;
    localparam logic [ADDR_W-1:0] AUNT = 65'h0_0000_0E00_0000_0000;
    localparam logic [PA_W-1:0]   ROOT = 64'h1_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              miss_valid;
    logic [64:0]       miss_addr;
    logic              miss_tr;
    logic              miss_ready;
    logic [PA_W-1:0]   root_base;
    logic              flush;
    logic              mem_req_valid;
    logic [PA_W-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [PTE_W-1:0]  mem_rsp_data;
    logic              wr_stall;
    logic              wr_wen;
    logic              wr_tr;
    logic [64:0]       wr_addr;
    logic [PTE_W-1:0]  wr_data;
    logic              fault_valid;
    logic [64:0]       fault_addr;
    logic              busy;

    cmlb_refill #(.PTE_W(PTE_W), .PA_W(PA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_tr       (miss_tr),
        .miss_ready    (miss_ready),
        .root_base     (root_base),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wr_stall      (wr_stall),
        .wr_wen        (wr_wen),
        .wr_tr         (wr_tr),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .fault_valid   (fault_valid),
        .fault_addr    (fault_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled shortly after each rising edge.
    int                wen_cnt = 0;
    int                fault_cnt = 0;
    int                req_cnt = 0;
    logic              wen_unstable = 1'b0;
    logic              prev_wen = 1'b0;
    logic [PTE_W-1:0]  last_wr_data = '0;
    logic [64:0]       last_wr_addr = '0;
    logic              last_wr_tr = 1'b0;
    logic [64:0]       last_fault_addr = '0;

    always @(posedge clk) begin
        #2;
        if (wr_wen) begin
            if (prev_wen && (wr_data !== last_wr_data || wr_addr !== last_wr_addr ||
                             wr_tr !== last_wr_tr))
                wen_unstable = 1'b1;
            wen_cnt++;
            last_wr_data = wr_data;
            last_wr_addr = wr_addr;
            last_wr_tr   = wr_tr;
        end
        prev_wen = wr_wen;
        if (fault_valid) begin
            fault_cnt++;
            last_fault_addr = fault_addr;
        end
        if (mem_req_valid) req_cnt++;
    end

    int wen0, fault0, req0;

    task automatic snap();
        wen0   = wen_cnt;
        fault0 = fault_cnt;
        req0   = req_cnt;
        wen_unstable = 1'b0;
    endtask

    // Present one miss for a single cycle; returns on the following falling edge.
    task automatic issue(input logic [64:0] a, input logic tr, input logic [PA_W-1:0] root);
        miss_valid = 1'b1;
        miss_addr  = a;
        miss_tr    = tr;
        root_base  = root;
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    // Wait for a request, check its address (also after holding ready low), accept it.
    task automatic handshake(input string tag, input logic [PA_W-1:0] exp_addr, input int hold);
        for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
        check({tag, " req_valid"}, mem_req_valid, 1'b1);
        check({tag, " req_addr"}, mem_req_addr, exp_addr);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({tag, " req_valid_held"}, mem_req_valid, 1'b1);
            check({tag, " req_addr_held"}, mem_req_addr, exp_addr);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [PA_W-1:0] exp_addr,
                         input logic [PTE_W-1:0] pte, input int hold, input int lat);
        handshake(tag, exp_addr, hold);
        repeat (lat) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pte;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; miss_tr = 1'b0; root_base = '0;
        flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        wr_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst miss_ready", miss_ready, 1'b1);
        check("rst outputs", {mem_req_valid, wr_wen, fault_valid, busy, wr_tr}, 5'b0);
        check("rst wr_data", wr_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full three-level walk to a 16 KB leaf.
        snap();
        issue(A1, 1'b1, ROOT);
        check("t1 busy", busy, 1'b1);
        check("t1 miss_ready_low", miss_ready, 1'b0);
        serve("t1 l0", 64'h1_0800, 64'h2_0001, 0, 1);
        serve("t1 l1", 64'h2_0008, 64'h3_0001, 2, 0);
        serve("t1 l2", 64'h3_0468, 64'h0ABC_C003, 0, 3);
        repeat (4) @(negedge clk);
        check("t1 wen_count", wen_cnt - wen0, 1);
        check("t1 wr_data", last_wr_data, 64'h0ABC_E003);
        check("t1 wr_addr", last_wr_addr, A1);
        check("t1 wr_tr", last_wr_tr, 1'b1);
        check("t1 no_fault", fault_cnt - fault0, 0);
        check("t1 idle", {miss_ready, busy}, 2'b10);

        // Invalid level-0 PTE faults.
        snap();
        issue(A2, 1'b0, ROOT);
        serve("t2 l0", 64'h1_0800, 64'h0, 0, 0);
        repeat (4) @(negedge clk);
        check("t2 fault_count", fault_cnt - fault0, 1);
        check("t2 fault_addr", last_fault_addr, A2);
        check("t2 no_wen", wen_cnt - wen0, 0);

        // Level-1 superpage leaf.
        snap();
        issue(A2, 1'b0, ROOT);
        serve("t3 l0", 64'h1_0800, 64'h2_0001, 0, 0);
        serve("t3 l1", 64'h2_0008, 64'h5_0003, 0, 0);
        repeat (4) @(negedge clk);
        check("t3 req_count", req_cnt - req0, 2);
        check("t3 wen_count", wen_cnt - wen0, 1);
        check("t3 wr_data", last_wr_data, 64'h5_1003);
        check("t3 wr_addr", last_wr_addr, A1);
        check("t3 wr_tr", last_wr_tr, 1'b0);

        // Non-leaf at the last level faults.
        snap();
        issue(A1, 1'b1, ROOT);
        serve("t3b l0", 64'h1_0800, 64'h2_0001, 0, 0);
        serve("t3b l1", 64'h2_0008, 64'h3_0001, 0, 0);
        serve("t3b l2", 64'h3_0468, 64'h4_0001, 0, 0);
        repeat (4) @(negedge clk);
        check("t3b fault_count", fault_cnt - fault0, 1);
        check("t3b no_wen", wen_cnt - wen0, 0);

        // Write held by stall for five cycles.
        snap();
        wr_stall = 1'b1;
        issue(A1, 1'b1, ROOT);
        serve("t4 l0", 64'h1_0800, 64'h2_0001, 0, 0);
        serve("t4 l1", 64'h2_0008, 64'h3_0001, 0, 0);
        serve("t4 l2", 64'h3_0468, 64'h0ABC_C003, 0, 0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_wen) begin
                k++;
                if (k >= 6) wr_stall = 1'b0;
            end
            @(negedge clk);
        end
        wr_stall = 1'b0;
        check("t4 wen_count", wen_cnt - wen0, 6);
        check("t4 stable", wen_unstable, 1'b0);
        check("t4 wr_data", last_wr_data, 64'h0ABC_E003);
        check("t4 idle", {miss_ready, busy}, 2'b10);

        // Flush in WAIT, response three cycles later is drained.
        snap();
        issue(A1, 1'b1, ROOT);
        handshake("t5", 64'h1_0800, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5 drain_busy", {miss_ready, busy, mem_req_valid}, 3'b010);
        @(negedge clk);
        check("t5 drain_hold", {miss_ready, busy}, 2'b01);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0ABC_C003;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("t5 idle_after_rsp", {miss_ready, busy}, 2'b10);
        repeat (3) @(negedge clk);
        check("t5 no_wen_fault", {32'(wen_cnt - wen0), 32'(fault_cnt - fault0)}, 0);

        // Flush together with the response goes straight to idle.
        snap();
        issue(A1, 1'b1, ROOT);
        handshake("t5b", 64'h1_0800, 0);
        flush = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0ABC_C003;
        @(negedge clk);
        flush = 1'b0;
        mem_rsp_valid = 1'b0;
        check("t5b idle", {miss_ready, busy}, 2'b10);
        repeat (3) @(negedge clk);
        check("t5b no_wen", wen_cnt - wen0, 0);

        // Flush in REQ without ready drops the request.
        issue(A1, 1'b1, ROOT);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5c idle", {miss_ready, busy, mem_req_valid}, 3'b100);

        // Flush blocks acceptance in IDLE; untranslated window retires immediately.
        snap();
        flush = 1'b1;
        issue(A1, 1'b1, ROOT);
        flush = 1'b0;
        check("t7 flush_idle", {miss_ready, busy}, 2'b10);
        issue(AUNT, 1'b1, ROOT);
        check("t7 untr_idle", {miss_ready, busy}, 2'b10);
        repeat (3) @(negedge clk);
        check("t7 no_req", req_cnt - req0, 0);
        check("t7 no_wen", wen_cnt - wen0, 0);

        // Reset mid-walk, late response ignored, then a clean walk.
        issue(A2, 1'b1, ROOT);
        handshake("t6", 64'h1_0800, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 miss_ready", miss_ready, 1'b1);
        check("t6 ctl_zero", {busy, mem_req_valid, wr_wen, fault_valid, wr_tr}, 5'b0);
        check("t6 req_addr_zero", mem_req_addr, 0);
        check("t6 wr_zero", {wr_addr, wr_data}, 0);
        check("t6 fault_addr_zero", fault_addr, 0);
        snap();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h0ABC_C003;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6 late_rsp_ignored", {miss_ready, busy, 32'(wen_cnt - wen0)}, {2'b10, 32'd0});
        issue(A1, 1'b0, ROOT);
        serve("t6 l0", 64'h1_0800, 64'h2_0001, 0, 0);
        serve("t6 l1", 64'h2_0008, 64'h3_0001, 0, 1);
        serve("t6 l2", 64'h3_0468, 64'h0ABC_C003, 0, 0);
        repeat (4) @(negedge clk);
        check("t6 wen_count", wen_cnt - wen0, 1);
        check("t6 wr_data", last_wr_data, 64'h0ABC_E003);
        check("t6 wr_addr", last_wr_addr, A1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
